alu_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares the single 8-bit `ALU` between two requesters, for example the execute FSM and a secondary unit. It accepts operand/opcode requests over valid/ready handshakes and drives the ALU for exactly one enabled cycle. It captures the result, the flags and the HI/LO product, then returns them to the winning requester over a held response handshake. It sits in the datapath between the requesters and the `ALU` instance.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/rr_arb2.sv | 30 +++
 rtl/alu_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode constants shared by the ALU and its arbiter, the
//               arbiter sequencer state encoding, and the opcode-support
//               predicate.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] OP_MUL  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] OP_SLL  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] OP_SRA  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] OP_NAND = 4'b1100;
  localparam logic [ALU_OP_W-1:0] OP_SLT  = 4'b1110;
  localparam logic [ALU_OP_W-1:0] OP_EQ   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // True when the ALU implements the opcode; anything else is answered
  // with an error response and the ALU is never enabled for it.
  function automatic logic op_supported(input logic [ALU_OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_SLL,
      OP_SRA, OP_NAND, OP_SLT, OP_EQ: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-way round-robin grant.
//               A lone requester always wins; on a tie the requester that
//               was not granted last wins.
// Ports       : req[1:0]    in  - request valids (bit N = requester N)
//               last_grant  in  - index of the previously served requester
//               gnt_valid   out - at least one requester is valid
//               gnt_idx     out - index of the winning requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    if (&req) begin
      gnt_idx = ~last_grant;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one external 8-bit ALU between two requesters.
//               A request is accepted in IDLE, the ALU is enabled for one
//               EXEC cycle, and the captured result is held in RESP until
//               the winning requester consumes it.
// Ports       : clk, rst                      - clock, async active-high reset
//               rN_req_valid/ready/a/b/op     - request channel, N = 0,1
//               rN_rsp_valid/ready            - response channel, N = 0,1
//               rsp_data/hi/lo/flags/err      - shared response payload
//               alu_a/b/op/enable             - ALU drive (registered)
//               alu_out/hi/lo, alu_overflow/lt/eq/zero - ALU results
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic [DATA_W-1:0] r0_req_a,
  input  logic [DATA_W-1:0] r0_req_b,
  input  logic [OP_W-1:0]   r0_req_op,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,

  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic [DATA_W-1:0] r1_req_a,
  input  logic [DATA_W-1:0] r1_req_b,
  input  logic [OP_W-1:0]   r1_req_op,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,

  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] rsp_hi,
  output logic [DATA_W-1:0] rsp_lo,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_enable,

  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] alu_hi,
  input  logic [DATA_W-1:0] alu_lo,
  input  logic              alu_overflow,
  input  logic              alu_lt,
  input  logic              alu_eq,
  input  logic              alu_zero
);

  arb_state_t        r_state;
  arb_state_t        w_next;

  logic              r_last_grant;
  logic              r_gnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [OP_W-1:0]   r_op;
  logic              r_alu_en;
  logic              r_rsp_valid0;
  logic              r_rsp_valid1;
  logic [DATA_W-1:0] r_rsp_data;
  logic [DATA_W-1:0] r_rsp_hi;
  logic [DATA_W-1:0] r_rsp_lo;
  logic [3:0]        r_rsp_flags;
  logic              r_rsp_err;

  logic              w_gnt_valid;
  logic              w_gnt_idx;
  logic              w_accept;
  logic              w_rsp_fire;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic [OP_W-1:0]   w_sel_op;

  rr_arb2 u_arb (
    .req        ({r1_req_valid, r0_req_valid}),
    .last_grant (r_last_grant),
    .gnt_valid  (w_gnt_valid),
    .gnt_idx    (w_gnt_idx)
  );

  // Ready is the only combinational output. It is masked by rst so that
  // both readies read 0 while reset is held, even with valids asserted.
  assign w_accept     = (r_state == ST_IDLE) && w_gnt_valid && !rst;
  assign r0_req_ready = w_accept && !w_gnt_idx;
  assign r1_req_ready = w_accept &&  w_gnt_idx;

  assign w_sel_a  = w_gnt_idx ? r1_req_a  : r0_req_a;
  assign w_sel_b  = w_gnt_idx ? r1_req_b  : r0_req_b;
  assign w_sel_op = w_gnt_idx ? r1_req_op : r0_req_op;

  // Only the latched winner can release the response; the other port's
  // rsp_ready has no effect.
  assign w_rsp_fire = (r_state == ST_RESP) &&
                      (r_gnt ? r1_rsp_ready : r0_rsp_ready);

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_next = ST_EXEC;
      ST_EXEC:                 w_next = ST_RESP;
      ST_RESP: if (w_rsp_fire) w_next = ST_IDLE;
      default:                 w_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand latch, ALU enable and response capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_alu_en     <= 1'b0;
      r_rsp_valid0 <= 1'b0;
      r_rsp_valid1 <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_hi     <= '0;
      r_rsp_lo     <= '0;
      r_rsp_flags  <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_op     <= w_sel_op;
            r_gnt    <= w_gnt_idx;
            // Enable is registered so it is high for exactly the EXEC
            // cycle, and never for an unsupported opcode.
            r_alu_en <= op_supported(w_sel_op);
          end
        end
        ST_EXEC: begin
          r_alu_en     <= 1'b0;
          r_rsp_valid0 <= !r_gnt;
          r_rsp_valid1 <=  r_gnt;
          if (op_supported(r_op)) begin
            r_rsp_data  <= alu_out;
            r_rsp_hi    <= alu_hi;
            r_rsp_lo    <= alu_lo;
            r_rsp_flags <= {alu_overflow, alu_lt, alu_eq, alu_zero};
            r_rsp_err   <= 1'b0;
          end else begin
            r_rsp_data  <= '0;
            r_rsp_hi    <= '0;
            r_rsp_lo    <= '0;
            r_rsp_flags <= '0;
            r_rsp_err   <= 1'b1;
          end
        end
        ST_RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_last_grant <= r_gnt;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign alu_op       = r_op;
  assign alu_enable   = r_alu_en;
  assign r0_rsp_valid = r_rsp_valid0;
  assign r1_rsp_valid = r_rsp_valid1;
  assign rsp_data     = r_rsp_data;
  assign rsp_hi       = r_rsp_hi;
  assign rsp_lo       = r_rsp_lo;
  assign rsp_flags    = r_rsp_flags;
  assign rsp_err      = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. A behavioural ALU
//               answers the DUT's drive signals; a transaction-level model
//               predicts grants, handshakes and response payloads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] o;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [3:0] fl;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0_req_valid, r1_req_valid;
  logic       r0_req_ready, r1_req_ready;
  logic [7:0] r0_req_a, r0_req_b, r1_req_a, r1_req_b;
  logic [3:0] r0_req_op, r1_req_op;
  logic       r0_rsp_valid, r1_rsp_valid;
  logic       r0_rsp_ready, r1_rsp_ready;
  logic [7:0] rsp_data, rsp_hi, rsp_lo;
  logic [3:0] rsp_flags;
  logic       rsp_err;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_op;
  logic       alu_enable;
  logic [7:0] alu_out, alu_hi, alu_lo;
  logic       alu_overflow, alu_lt, alu_eq, alu_zero;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(8), .OP_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .r0_req_valid (r0_req_valid),
    .r0_req_ready (r0_req_ready),
    .r0_req_a     (r0_req_a),
    .r0_req_b     (r0_req_b),
    .r0_req_op    (r0_req_op),
    .r0_rsp_valid (r0_rsp_valid),
    .r0_rsp_ready (r0_rsp_ready),
    .r1_req_valid (r1_req_valid),
    .r1_req_ready (r1_req_ready),
    .r1_req_a     (r1_req_a),
    .r1_req_b     (r1_req_b),
    .r1_req_op    (r1_req_op),
    .r1_rsp_valid (r1_rsp_valid),
    .r1_rsp_ready (r1_rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_hi       (rsp_hi),
    .rsp_lo       (rsp_lo),
    .rsp_flags    (rsp_flags),
    .rsp_err      (rsp_err),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_enable   (alu_enable),
    .alu_out      (alu_out),
    .alu_hi       (alu_hi),
    .alu_lo       (alu_lo),
    .alu_overflow (alu_overflow),
    .alu_lt       (alu_lt),
    .alu_eq       (alu_eq),
    .alu_zero     (alu_zero)
  );

  // Behavioural ALU. Unsupported opcodes produce deliberately non-zero
  // junk so that a response which fails to zero it is visible.
  function automatic res_t alu_model(input logic [7:0] a, input logic [7:0] b,
                                     input logic [3:0] op);
    res_t        r;
    logic [15:0] p;
    logic [7:0]  d;
    logic        ov;
    r  = '0;
    ov = 1'b0;
    d  = a - b;
    p  = 16'(a) * 16'(b);
    case (op)
      OP_ADD:  begin r.o = a + b; ov = (a[7] == b[7]) && (r.o[7] != a[7]); end
      OP_SUB:  begin r.o = d;     ov = (a[7] != b[7]) && (d[7] != a[7]);   end
      OP_MUL:  begin r.o = p[7:0]; r.hi = p[15:8]; r.lo = p[7:0];          end
      OP_SLL:  r.o = a << b[2:0];
      OP_SRA:  r.o = $unsigned($signed(a) >>> b[2:0]);
      OP_NAND: r.o = ~(a & b);
      OP_SLT:  begin
                 r.o = {7'd0, ($signed(a) < $signed(b))};
                 ov  = (a[7] != b[7]) && (d[7] != a[7]);
               end
      OP_EQ:   r.o = {7'd0, (a == b)};
      default: begin
                 r.o  = a ^ b ^ 8'h5A;
                 r.hi = 8'hAA;
                 r.lo = 8'h55;
                 r.fl = 4'hF;
                 return r;
               end
    endcase
    r.fl = {ov, ($signed(a) < $signed(b)), (a == b), (r.o == 8'd0)};
    return r;
  endfunction

  res_t w_alu;
  always_comb begin
    w_alu        = alu_model(alu_a, alu_b, alu_op);
    alu_out      = w_alu.o;
    alu_hi       = w_alu.hi;
    alu_lo       = w_alu.lo;
    alu_overflow = w_alu.fl[3];
    alu_lt       = w_alu.fl[2];
    alu_eq       = w_alu.fl[1];
    alu_zero     = w_alu.fl[0];
  end

  function automatic logic tb_supported(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'hC, 4'hE, 4'hF};
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transaction model: phase 0 = free, 1 = operation in the ALU,
  // 2 = response offered to the owner.
  int         m_phase;
  logic       m_last;
  logic       m_g;
  logic [7:0] m_a, m_b;
  logic [3:0] m_op;
  logic       m_err;
  res_t       m_exp;

  // Last response seen on each port, and grants seen on the ready lines.
  logic [7:0] o0_data, o0_hi, o0_lo, o1_data, o1_hi, o1_lo;
  logic [3:0] o0_flags, o1_flags;
  logic       o0_err, o1_err;
  int         gq[$];

  task automatic model_reset();
    m_phase = 0;
    m_last  = 1'b1;
  endtask

  task automatic reset_check(input string tag);
    check(tag, 64'({r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, alu_enable,
                    alu_a, alu_b, alu_op, rsp_data, rsp_hi, rsp_lo, rsp_flags, rsp_err}),
          64'(0));
  endtask

  // Called at posedge+1 with inputs already set for this cycle.
  task automatic tick();
    logic e_r0, e_r1, acc0, acc1, fire;
    #1;
    e_r0 = (m_phase == 0) && r0_req_valid && (!r1_req_valid ||  m_last);
    e_r1 = (m_phase == 0) && r1_req_valid && (!r0_req_valid || !m_last);
    check("req_ready0", 64'(r0_req_ready), 64'(e_r0));
    check("req_ready1", 64'(r1_req_ready), 64'(e_r1));
    if (r0_req_ready) gq.push_back(0);
    if (r1_req_ready) gq.push_back(1);
    check("alu_enable", 64'(alu_enable), 64'((m_phase == 1) && !m_err));
    check("rsp_valid0", 64'(r0_rsp_valid), 64'((m_phase == 2) && !m_g));
    check("rsp_valid1", 64'(r1_rsp_valid), 64'((m_phase == 2) &&  m_g));
    if (m_phase != 0)
      check("alu_drive", 64'({alu_a, alu_b, alu_op}), 64'({m_a, m_b, m_op}));
    if (m_phase == 2)
      check("rsp_payload", 64'({rsp_data, rsp_hi, rsp_lo, rsp_flags, rsp_err}),
            64'({m_exp, m_err}));
    if (r0_rsp_valid) begin
      o0_data = rsp_data; o0_hi = rsp_hi; o0_lo = rsp_lo; o0_flags = rsp_flags; o0_err = rsp_err;
    end
    if (r1_rsp_valid) begin
      o1_data = rsp_data; o1_hi = rsp_hi; o1_lo = rsp_lo; o1_flags = rsp_flags; o1_err = rsp_err;
    end
    acc0 = 1'b0;
    acc1 = 1'b0;
    case (m_phase)
      0: if (e_r0 || e_r1) begin
           m_g     = e_r1;
           m_a     = m_g ? r1_req_a  : r0_req_a;
           m_b     = m_g ? r1_req_b  : r0_req_b;
           m_op    = m_g ? r1_req_op : r0_req_op;
           m_err   = !tb_supported(m_op);
           m_exp   = m_err ? '0 : alu_model(m_a, m_b, m_op);
           m_phase = 1;
           acc0    = e_r0;
           acc1    = e_r1;
         end
      1: m_phase = 2;
      default: begin
           fire = m_g ? r1_rsp_ready : r0_rsp_ready;
           if (fire) begin
             m_last  = m_g;
             m_phase = 0;
           end
         end
    endcase
    @(posedge clk);
    #1;
    if (acc0) r0_req_valid = 1'b0;
    if (acc1) r1_req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_check("reset_values");
    rst = 1'b0;
  endtask

  task automatic set_r0(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    r0_req_valid = 1'b1; r0_req_a = a; r0_req_b = b; r0_req_op = op;
  endtask

  task automatic set_r1(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    r1_req_valid = 1'b1; r1_req_a = a; r1_req_b = b; r1_req_op = op;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    r0_req_a = '0; r0_req_b = '0; r0_req_op = '0;
    r1_req_a = '0; r1_req_b = '0; r1_req_op = '0;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    m_g = 1'b0; m_a = '0; m_b = '0; m_op = '0; m_err = 1'b0; m_exp = '0;
    o0_data = '0; o0_hi = '0; o0_lo = '0; o0_flags = '0; o0_err = 1'b0;
    o1_data = '0; o1_hi = '0; o1_lo = '0; o1_flags = '0; o1_err = 1'b0;
    do_reset();

    // Single ADD on r0.
    set_r0(8'd5, 8'd3, OP_ADD);
    repeat (4) tick();
    check("add_data",  64'(o0_data),  64'(8'd8));
    check("add_flags", 64'(o0_flags), 64'(4'b0000));

    // Both requesters continuously valid from a fresh reset.
    do_reset();
    gq.delete();
    set_r0(8'd4, 8'd4, OP_SUB);
    set_r1(8'd16, 8'd16, OP_MUL);
    for (int i = 0; i < 9; i++) begin
      tick();
      r0_req_valid = 1'b1;
      r1_req_valid = 1'b1;
    end
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    check("alt_grant_count", 64'(gq.size()), 64'(3));
    if (gq.size() >= 3) begin
      check("alt_grant0", 64'(gq[0]), 64'(0));
      check("alt_grant1", 64'(gq[1]), 64'(1));
      check("alt_grant2", 64'(gq[2]), 64'(0));
    end
    check("sub_data", 64'(o0_data),     64'(0));
    check("sub_zero", 64'(o0_flags[0]), 64'(1));
    check("mul_hilo", 64'({o1_hi, o1_lo}), 64'(16'h0100));

    // Signed less-than with overflowing subtraction.
    set_r1(8'h80, 8'h01, OP_SLT);
    repeat (4) tick();
    check("slt_data", 64'(o1_data),     64'(1));
    check("slt_lt",   64'(o1_flags[2]), 64'(1));
    check("slt_ov",   64'(o1_flags[3]), 64'(1));

    // Unsupported opcode.
    set_r0(8'h12, 8'h34, 4'b0011);
    repeat (4) tick();
    check("bad_err",     64'(o0_err), 64'(1));
    check("bad_payload", 64'({o0_data, o0_hi, o0_lo, o0_flags}), 64'(0));

    // Response stall on r0 while r1 waits.
    r0_rsp_ready = 1'b0;
    set_r0(8'd7, 8'd9, OP_ADD);
    repeat (3) tick();
    set_r1(8'hF0, 8'h3C, OP_NAND);
    repeat (10) tick();
    r0_rsp_ready = 1'b1;
    tick();
    gq.delete();
    tick();
    check("stall_grant_count", 64'(gq.size()), 64'(1));
    if (gq.size() >= 1) check("stall_grant", 64'(gq[0]), 64'(1));
    repeat (2) tick();

    // Reset while the ALU is executing.
    set_r0(8'd9, 8'd2, OP_SUB);
    tick();
    rst = 1'b1;
    model_reset();
    #1;
    reset_check("reset_in_exec");
    @(posedge clk);
    #1;
    reset_check("reset_hold");
    rst = 1'b0;
    gq.delete();
    set_r0(8'd1, 8'd2, OP_ADD);
    set_r1(8'd3, 8'd4, OP_ADD);
    tick();
    check("post_reset_count", 64'(gq.size()), 64'(1));
    if (gq.size() >= 1) check("post_reset_winner", 64'(gq[0]), 64'(0));

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if (!r0_req_valid && $urandom_range(0, 2) == 0)
        set_r0(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
      if (!r1_req_valid && $urandom_range(0, 2) == 0)
        set_r1(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
      r0_rsp_ready = ($urandom_range(0, 3) != 0);
      r1_rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
